seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Shares a single segment bus between NUM_DIGITS BCD digits: a digit slot for each digit, with a blanking gap between slots to suppress ghosting.
- Double-buffers the digit values so each displayed frame is coherent.
- Flags invalid (non-BCD) digits per position. Sits between the counter/arithmetic datapath and the board display pins.

---
 rtl/seg7_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros on every digit except digit 0.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_start
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_wrap;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   lz_mask;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      seg_q         <= 7'b1111111;
      an_q          <= '1;
      err_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      err_q         <= err_d;
      frame_start_q <= frame_start_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    active_d   = active_q;
    frame_wrap = 1'b0;
    shadow_d   = load ? digits_in : shadow_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d      = '0;
            frame_wrap = 1'b1;
            // A load on this same edge lands in shadow and waits a full frame.
            active_d   = shadow_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (active_d[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    an_d          = '1;
    seg_d         = 7'b1111111;
    err_d         = err_q;
    frame_start_d = frame_wrap;
    cur_digit     = 4'(active_d >> {idx_d, 2'b00});
    if (frame_wrap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        err_d[i] = active_d[4*i +: 4] > 4'd9;
      end
    end
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = lz_mask[idx_d] ? 7'b1111111 : decode(cur_digit);
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign err         = err_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: slot/frame arithmetic model plus literal pins.
// Build with LEADING_ZERO_BLANK_EN defined to check leading-zero suppression.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = SD + BC;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [ND-1:0] err;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .seg(seg), .an(an), .err(err), .frame_start(frame_start));

  always #5 clk = ~clk;

  // Model: m_k counts edges since the last reset edge; everything else follows from it.
  int          m_k = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_active = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0; m_shadow = '0; m_active = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_k++;
      if (m_k % FRAME == 0) m_active = m_shadow;
      if (load) m_shadow = digits_in;
    end
  end

  function automatic logic [6:0] exp_seg(input int k, input logic [15:0] act);
    int s = (k / SLOT) % ND;
    if (k % SLOT < BC) return 7'b1111111;
    if (LZB && s > 0 && (act >> (4 * s)) == 16'h0) return 7'b1111111;
    return DEC[act[4*s +: 4]];
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    int s = (k / SLOT) % ND;
    if (k % SLOT < BC) return 4'b1111;
    return ~(4'b0001 << s);
  endfunction

  function automatic logic [3:0] exp_err(input logic [15:0] act);
    logic [3:0] e;
    for (int i = 0; i < ND; i++) e[i] = act[4*i +: 4] > 4'd9;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, m_k, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_an", 32'(an), 32'(exp_an(m_k)));
      check("model_seg", 32'(seg), 32'(exp_seg(m_k, m_active)));
      check("model_err", 32'(err), 32'(exp_err(m_active)));
      check("model_frame_start", 32'(frame_start), 32'(m_k > 0 && m_k % FRAME == 0));
    end
  end

  task automatic wait_k(input int target);
    int n = 0;
    while (!(m_valid && !rst && m_k == target)) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        check("wait_timeout", 32'(m_k), 32'(target));
        return;
      end
    end
  endtask

  task automatic load_at(input int k_edge, input logic [15:0] v);
    wait_k(k_edge - 1);
    digits_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pin(input string name, input int k, input logic [3:0] e_an, input logic [6:0] e_seg);
    wait_k(k);
    check({name, "_an"}, 32'(an), 32'(e_an));
    check({name, "_seg"}, 32'(seg), 32'(e_seg));
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    int nz;
    if ($urandom % 3 == 0) return 16'($urandom);
    for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'($urandom % 10);
    nz = $urandom % 5;
    for (int i = ND - nz; i < ND; i++) v[4*i +: 4] = 4'd0;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset and first slot
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_an", 32'(an), 32'hF);
    pin("slot0", 2, 4'b1110, 7'b1000000);
    // Frame-coherent load
    load_at(5, 16'h1234);
    pin("slot1_old", 12, 4'b1101, 7'b1000000);
    pin("slot3_old", 39, 4'b0111, LZB ? 7'b1111111 : 7'b1000000);
    wait_k(40);
    check("fs_first", 32'(frame_start), 32'h1);
    pin("d0_4", 42, 4'b1110, 7'b0011001);
    load_at(45, 16'h0A09);
    pin("d1_3", 52, 4'b1101, 7'b0110000);
    pin("d2_2", 62, 4'b1011, 7'b0100100);
    pin("d3_1", 72, 4'b0111, 7'b1111001);
    // Invalid digit
    wait_k(80);
    check("inv_fs", 32'(frame_start), 32'h1);
    check("inv_err", 32'(err), 32'b0100);
    pin("inv_d0", 82, 4'b1110, 7'b0010000);
    pin("inv_d2", 102, 4'b1011, 7'b0111111);
    // Load on the wrap edge
    load_at(120, 16'h5555);
    check("wrap_err_held", 32'(err), 32'b0100);
    pin("wrap_old", 122, 4'b1110, 7'b0010000);
    wait_k(160);
    check("wrap_new_err", 32'(err), 32'h0);
    pin("wrap_new_d0", 162, 4'b1110, 7'b0010010);
    pin("wrap_new_d3", 192, 4'b0111, 7'b0010010);
    // Randomized traffic, occasional resets
    repeat (1500) begin
      @(negedge clk);
      rst = ($urandom % 400 == 0);
      load = ($urandom % 6 == 0);
      digits_in = rand_digits();
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    // Reset mid-SHOW
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_at(3, 16'h9A99);
    pin("mid_d2", 62, 4'b1011, 7'b0111111);
    check("mid_err", 32'(err), 32'b0100);
    wait_k(65);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    pin("mid_restart0", 2, 4'b1110, 7'b1000000);
    pin("mid_restart1", 12, 4'b1101, 7'b1000000);
    // Leading-zero suppression
    load_at(15, 16'h0050);
    pin("lz_d0", 42, 4'b1110, 7'b1000000);
    pin("lz_d1", 52, 4'b1101, 7'b0010010);
    pin("lz_d2", 62, 4'b1011, LZB ? 7'b1111111 : 7'b1000000);
    pin("lz_d3", 72, 4'b0111, LZB ? 7'b1111111 : 7'b1000000);
    load_at(75, 16'h0000);
    pin("lz0_d0", 82, 4'b1110, 7'b1000000);
    pin("lz0_d1", 92, 4'b1101, LZB ? 7'b1111111 : 7'b1000000);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
